// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART transmit path.
//            Covers parity modes, one-hot FSM encodings and bit-period math.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Four-character ASCII tags used for the PARITY parameter
    localparam logic [31:0] MODE_NONE = "NONE";
    localparam logic [31:0] MODE_ODD  = {8'd0, "ODD"};
    localparam logic [31:0] MODE_EVEN = "EVEN";

    // One-hot transmitter states
    localparam int             ST_W     = 5;
    localparam logic [ST_W-1:0] S_IDLE   = 5'b00001;
    localparam logic [ST_W-1:0] S_START  = 5'b00010;
    localparam logic [ST_W-1:0] S_DATA   = 5'b00100;
    localparam logic [ST_W-1:0] S_PARITY = 5'b01000;
    localparam logic [ST_W-1:0] S_STOP   = 5'b10000;

    // Clocks per bit period, truncated
    function automatic int calc_div(input int clock, input int baud);
        return clock / baud;
    endfunction

    // Decode the ASCII parity tag; anything unrecognised means no parity
    function automatic parity_e parity_mode(input logic [31:0] mode);
        if (mode == MODE_ODD)  return PAR_ODD;
        if (mode == MODE_EVEN) return PAR_EVEN;
        return PAR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_if
// Purpose  : Write-side handshake and line/status signals of uart_tx_fifo.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]           tx_data;
    logic                           tx_data_vld;
    logic                           ready;
    logic                           tx;
    logic                           busy;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;
    logic                           overflow;

    modport master (
        output tx_data, tx_data_vld,
        input  ready, tx, busy, fifo_count, overflow
    );

    modport slave (
        input  tx_data, tx_data_vld,
        output ready, tx, busy, fifo_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock show-ahead FIFO; head word visible on dout.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop,
    input  wire logic [WIDTH-1:0]         din,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Pointer/count registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered UART transmitter, LSB first, optional parity, 1/2 stop.
//            Frames stream back-to-back while the FIFO holds data.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int          CLOCK      = 50_000_000,
    parameter int          BAUD       = 9600,
    parameter int          DATA_BITS  = 8,
    parameter logic [31:0] PARITY     = "NONE",
    parameter int          STOP_BITS  = 1,
    parameter int          FIFO_DEPTH = 16
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_fifo_if.slave   bus
);
    localparam int      DIV   = calc_div(CLOCK, BAUD);
    localparam int      CNT_W = $clog2(DIV);
    localparam parity_e PMODE = parity_mode(PARITY);

    logic [ST_W-1:0]             state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]        shift_q, shift_d;
    logic                        tx_q, tx_d;

    logic                        fifo_full, fifo_empty, push, pop;
    logic [DATA_BITS-1:0]        fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic                        bit_end, last_data, last_stop, par_bit;

    // Readiness is judged before any pop this cycle, so a full FIFO drops the write
    assign push      = bus.tx_data_vld && !fifo_full;

    assign bit_end   = (cnt_q == CNT_W'(DIV - 1));
    assign last_data = (bit_idx_q == 3'(DATA_BITS - 1));
    assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));
    assign par_bit   = (PMODE == PAR_ODD) ? ~^shift_q : ^shift_q;

    assign bus.ready      = !fifo_full;
    assign bus.overflow   = bus.tx_data_vld && fifo_full;
    assign bus.fifo_count = fifo_cnt;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.tx         = tx_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: advance at each bit end, chain frames while data is queued
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!fifo_empty) state_d = S_START;
            S_START:  if (bit_end) state_d = S_DATA;
            S_DATA:   if (bit_end && last_data)
                          state_d = (PMODE != PAR_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (bit_end) state_d = S_STOP;
            S_STOP:   if (bit_end && last_stop)
                          state_d = fifo_empty ? S_IDLE : S_START;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: baud/bit counters, word capture on pop, next line level
    always_comb begin
        pop       = 1'b0;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;

        if (state_d != state_q) begin
            cnt_d     = '0;
            bit_idx_d = '0;
        end else if (state_q != S_IDLE) begin
            if (bit_end) begin
                cnt_d     = '0;
                bit_idx_d = bit_idx_q + 3'd1;
            end else begin
                cnt_d     = cnt_q + CNT_W'(1);
            end
        end

        // Entering START always consumes the FIFO head
        if (state_d == S_START && state_q != S_START) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
        end

        // tx is registered, so it is derived from the state being entered
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[bit_idx_d];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    // Datapath registers; line idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLOCK, 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, 9600, line rate in bit/s; bit period DIV = CLOCK/BAUD clocks (integer divide), legal DIV >= 4.
REQ-003 Parameter DATA_BITS, 8, payload width; legal 5..8.
REQ-004 Parameter PARITY, "NONE", parity mode; legal "NONE", "ODD", "EVEN".
REQ-005 Parameter STOP_BITS, 1, stop-bit count; legal 1 or 2.
REQ-006 Parameter FIFO_DEPTH, 16, transmit buffer entries; power of two, >= 2.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 tx_data  in  DATA_BITS  word to transmit.
REQ-010 tx_data_vld  in  1  write request; accepted when tx_data_vld && ready.
REQ-011 ready  out  1  FIFO not full (combinational from count).
REQ-012 tx  out  1  serial line, idle high, LSB first; registered.
REQ-013 busy  out  1  high while FSM not IDLE.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered.
REQ-015 overflow  out  1  one-cycle pulse when tx_data_vld && !ready.

Function
REQ-016 FSM states IDLE, START, DATA, PARITY, STOP; one-hot encoding.
REQ-017 Baud counter runs 0..DIV-1 in every non-IDLE state, clears on state entry; bit_end = (count == DIV-1).
REQ-018 IDLE -> START when FIFO non-empty; pop and latch head word in that same cycle; tx falls low on the next clock edge.
REQ-019 START holds tx=0 for DIV cycles, then -> DATA.
REQ-020 DATA drives shift_reg[bit_idx], bit_idx 0..DATA_BITS-1, DIV cycles each; after last bit -> PARITY if PARITY != "NONE", else STOP.
REQ-021 Parity bit: ODD = ~^word, EVEN = ^word, computed over DATA_BITS bits only; held DIV cycles, then -> STOP.
REQ-022 STOP holds tx=1 for STOP_BITS*DIV cycles.
REQ-023 At STOP end: FIFO non-empty -> pop and go directly to START (no idle cycle between frames); else -> IDLE.
REQ-024 Frame length = (1 + DATA_BITS + (PARITY!="NONE") + STOP_BITS) * DIV clocks exactly.
REQ-025 Write when full is dropped, FIFO unchanged, overflow pulses; a pop in the same cycle does not rescue it (ready sampled before pop).
REQ-026 Simultaneous accepted write and pop: fifo_count unchanged, both take effect.
REQ-027 Pointers wrap modulo FIFO_DEPTH; fifo_count distinguishes full (FIFO_DEPTH) from empty (0).
REQ-028 tx_data changes after acceptance do not affect the queued or in-flight word.

Reset
REQ-029 On rst: FSM IDLE, tx=1, busy=0, FIFO emptied (fifo_count=0, ready=1), overflow=0, counters 0; effective immediately, including mid-frame.
REQ-030 Aborted frame is discarded, not resumed, after reset release.

Structure
REQ-031 Package uart_pkg holds parity-mode constants, FSM state encodings and DIV computation function.
REQ-032 FIFO is a separate sub-module sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count).

Verification (CLOCK=1_000_000, BAUD=100_000, DIV=10 unless stated)
REQ-033 8N1, write 0x55 while idle -> tx low cycles 1-10 after accept, then 1,0,1,0,1,0,1,0 at 10 cycles each, high 10 cycles; busy 100 cycles.
REQ-034 DATA_BITS=7, PARITY="ODD", write 0x07 -> parity bit 0; PARITY="EVEN" -> parity bit 1; frame 100 cycles with 1 stop.
REQ-035 FIFO_DEPTH=16, tx_data_vld high 18 consecutive cycles from idle -> 17 words accepted (first popped next cycle), 18th dropped with single overflow pulse, fifo_count peaks 16.
REQ-036 STOP_BITS=2, queue 0xA5,0x3C -> tx high exactly 20 cycles after first frame's last data bit, second start bit follows with no gap.
REQ-037 rst asserted at cycle 35 of a frame with 3 words queued -> tx=1, fifo_count=0, busy=0 same cycle; after release tx stays high, no further frames.
